// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared state type and constant helper for the binary neural layer
package bnn_pkg;

    // Layer sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } bnn_state_e;

    // Ceiling log2, usable in parameter and port-width expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bnn_popcount.sv
// rtl/bnn_popcount.sv - combinational population count
// Ports:
//   data_i  [WIDTH]               bit vector to count
//   count_o [clog2(WIDTH+1)]      number of ones in data_i
module bnn_popcount
    import bnn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]               data_i,
    output logic [clog2(WIDTH+1)-1:0]      count_o
);

    localparam int CW = clog2(WIDTH + 1);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(data_i[i]);
        end
    end

endmodule

// File: rtl/bnn_seq_layer.sv
// rtl/bnn_seq_layer.sv - sequential binary neural network layer, one neuron per cycle
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   cfg_valid/cfg_ready/cfg_data    config stream {threshold, weights} for neuron cfg_ptr
//   in_valid/in_ready/in_data       binary activation vector stream
//   out_valid/out_ready/out_data    layer result stream, bit k = neuron k
//   cfg_done                        every neuron written at least once since reset
module bnn_seq_layer
    import bnn_pkg::*;
#(
    parameter int N_IN      = 8,
    parameter int N_NEURONS = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [N_IN+clog2(N_IN+1)-1:0]        cfg_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_IN-1:0]                      in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [N_NEURONS-1:0]                 out_data,
    output logic                                 cfg_done
);

    localparam int                THR_W    = clog2(N_IN + 1);
    localparam int                PTR_W    = clog2(N_NEURONS);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_NEURONS - 1);
    localparam logic [THR_W-1:0]  N_IN_T   = THR_W'(N_IN);
    localparam logic [THR_W-1:0]  THR_RST  = THR_W'(N_IN / 2);

    bnn_state_e             state_q, state_d;
    logic [PTR_W-1:0]       cfg_ptr_q, cfg_ptr_d;
    logic [PTR_W-1:0]       n_q, n_d;
    logic                   cfg_done_q, cfg_done_d;
    logic [N_IN-1:0]        x_q, x_d;
    logic [N_NEURONS-1:0]   shadow_q, shadow_d;
    logic [N_NEURONS-1:0]   out_q, out_d;
    logic                   cfg_we;

    logic [N_IN-1:0]        weights_q [N_NEURONS];
    logic [THR_W-1:0]       thr_q     [N_NEURONS];

    logic [N_IN-1:0]        mismatch;
    logic [THR_W-1:0]       pop;
    logic [THR_W-1:0]       score;
    logic                   neuron_bit;

    // Weight/threshold file, written only on an accepted config word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                weights_q[i] <= '0;
                thr_q[i]     <= THR_RST;
            end
        end else if (cfg_we) begin
            weights_q[cfg_ptr_q] <= cfg_data[N_IN-1:0];
            thr_q[cfg_ptr_q]     <= cfg_data[N_IN +: THR_W];
        end
    end

    // XNOR-popcount neuron: score counts agreeing bits between input and weights
    assign mismatch = x_q ^ weights_q[n_q];

    bnn_popcount #(
        .WIDTH (N_IN)
    ) u_popcount (
        .data_i  (mismatch),
        .count_o (pop)
    );

    // Unsigned compare: thr=0 always fires, thr>N_IN never does
    assign score      = N_IN_T - pop;
    assign neuron_bit = (score >= thr_q[n_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cfg_ptr_q  <= '0;
            n_q        <= '0;
            cfg_done_q <= 1'b0;
            x_q        <= '0;
            shadow_q   <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            cfg_ptr_q  <= cfg_ptr_d;
            n_q        <= n_d;
            cfg_done_q <= cfg_done_d;
            x_q        <= x_d;
            shadow_q   <= shadow_d;
            out_q      <= out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cfg_ptr_d  = cfg_ptr_q;
        n_d        = n_q;
        cfg_done_d = cfg_done_q;
        x_d        = x_q;
        shadow_d   = shadow_q;
        out_d      = out_q;
        cfg_we     = 1'b0;
        cfg_ready  = 1'b0;
        in_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                // Config takes priority over an input offered in the same cycle
                in_ready  = ~cfg_valid;
                if (cfg_valid) begin
                    cfg_we = 1'b1;
                    if (cfg_ptr_q == LAST_IDX) begin
                        cfg_ptr_d  = '0;
                        cfg_done_d = 1'b1;
                    end else begin
                        cfg_ptr_d = cfg_ptr_q + 1'b1;
                    end
                end else if (in_valid) begin
                    x_d     = in_data;
                    n_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                shadow_d[n_q] = neuron_bit;
                if (n_q == LAST_IDX) begin
                    // Publish the complete vector, including this cycle's bit
                    out_d   = shadow_d;
                    n_d     = '0;
                    state_d = HOLD;
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = (state_q == HOLD);
    assign out_data  = out_q;
    assign cfg_done  = cfg_done_q;

endmodule
